ofm_packer: RTL

OFM_PACKER -- requirements
Module: ofm_packer

---
 rtl/ofm_packer.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/ofm_packer.sv
// ofm_packer: packs an int8 OFM pixel stream into 128-bit words across two
// ping-pong banks and hands each full bank to an AXI writer as one burst.
// Optional build macro: OFM_PACK_RELU_EN (clamp negative pixels to zero on store).
module ofm_packer #(
    parameter int BURST_LEN  = 128,
    parameter int BUF_ADDR_W = 10,
    parameter int ADDR_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  layer_start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic                  px_valid,
    input  logic [7:0]            px_data,
    input  logic                  px_last,
    output logic                  px_ready,
    output logic                  start_write,
    output logic [ADDR_W-1:0]     wr_addr,
    input  logic                  wr_done,
    input  logic [BUF_ADDR_W-1:0] rd_addr,
    output logic [127:0]          rd_data,
    output logic [15:0]           rd_strb,
    output logic                  layer_done
);

    localparam int MEM_DEPTH = 2 * BURST_LEN;
    localparam int MEM_AW    = $clog2(MEM_DEPTH);
    localparam int CNT_W     = $clog2(BURST_LEN + 1);
    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * 16);
    localparam logic [CNT_W-1:0]  BURST_CNT   = CNT_W'(BURST_LEN);

    typedef enum logic [1:0] {
        B_FREE,
        B_FILLING,
        B_FULL,
        B_DRAINING
    } bank_state_t;

    typedef enum logic [1:0] {
        D_IDLE,
        D_REQ,
        D_WAIT
    } drain_state_t;

    bank_state_t  bank_state [2];
    logic [CNT_W-1:0] bank_cnt [2];
    logic         bank_last [2];
    drain_state_t drain_state;
    drain_state_t drain_next;

    logic              fill_bank;
    logic              drain_bank;
    logic [CNT_W-1:0]  wcnt;
    logic [CNT_W-1:0]  wcnt_inc;
    logic [3:0]        lane;
    logic [6:0]        lane_base;
    logic [127:0]      word_buf;
    logic [127:0]      word_next;
    logic [15:0]       strb_next;
    logic [7:0]        px_store;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] burst_idx;

    logic accept;
    logic commit;
    logic seal;
    logic retire;
    logic drain_go;
    logic start_ok;

    logic [MEM_AW-1:0] wr_idx;
    logic [MEM_AW-1:0] rd_idx;
    logic              rd_in_range;

    logic [127:0] data_mem [MEM_DEPTH];
    logic [15:0]  strb_mem [MEM_DEPTH];

    // Fill side: pixels are accepted whenever the fill bank can still take data.
    assign px_ready = (bank_state[fill_bank] == B_FREE) ||
                      (bank_state[fill_bank] == B_FILLING);
    assign accept   = px_valid && px_ready;

`ifdef OFM_PACK_RELU_EN
    assign px_store = px_data[7] ? 8'h00 : px_data;
`else
    assign px_store = px_data;
`endif

    assign lane_base = {lane, 3'b000};
    assign wcnt_inc  = wcnt + CNT_W'(1);
    assign commit    = accept && ((lane == 4'd15) || px_last);
    assign seal      = commit && ((wcnt_inc == BURST_CNT) || px_last);
    assign strb_next = 16'hFFFF >> (4'd15 - lane);
    assign wr_idx    = MEM_AW'(int'(fill_bank) * BURST_LEN + int'(wcnt));

    // Lane 0 starts a fresh word so lanes past a px_last stay zero.
    always_comb begin
        word_next = (lane == 4'd0) ? '0 : word_buf;
        word_next[lane_base +: 8] = px_store;
    end

    // Drain FSM: one burst request per sealed bank, oldest bank first.
    always_comb begin
        drain_next  = drain_state;
        start_write = 1'b0;
        case (drain_state)
            D_IDLE: begin
                if (bank_state[drain_bank] == B_FULL) begin
                    drain_next = D_REQ;
                end
            end
            D_REQ: begin
                start_write = 1'b1;
                drain_next  = D_WAIT;
            end
            D_WAIT: begin
                if (wr_done) begin
                    drain_next = D_IDLE;
                end
            end
            default: drain_next = D_IDLE;
        endcase
    end

    assign drain_go = (drain_state == D_IDLE) && (drain_next == D_REQ);
    assign retire   = (drain_state == D_WAIT) && wr_done;
    assign start_ok = layer_start && (drain_state == D_IDLE) &&
                      (bank_state[0] == B_FREE) && (bank_state[1] == B_FREE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_state <= D_IDLE;
        end else begin
            drain_state <= drain_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                bank_state[i] <= B_FREE;
                bank_cnt[i]   <= '0;
                bank_last[i]  <= 1'b0;
            end
            fill_bank  <= 1'b0;
            drain_bank <= 1'b0;
            wcnt       <= '0;
            lane       <= '0;
            word_buf   <= '0;
            base_q     <= '0;
            burst_idx  <= '0;
            wr_addr    <= '0;
            layer_done <= 1'b0;
        end else begin
            layer_done <= 1'b0;

            if (start_ok) begin
                base_q    <= base_addr;
                burst_idx <= '0;
            end

            if (accept) begin
                word_buf <= word_next;
                if (bank_state[fill_bank] == B_FREE) begin
                    bank_state[fill_bank] <= B_FILLING;
                end
                if (commit) begin
                    lane <= '0;
                end else begin
                    lane <= lane + 4'd1;
                end
            end

            if (commit) begin
                if (seal) begin
                    bank_state[fill_bank] <= B_FULL;
                    bank_cnt[fill_bank]   <= wcnt_inc;
                    bank_last[fill_bank]  <= px_last;
                    fill_bank             <= ~fill_bank;
                    wcnt                  <= '0;
                end else begin
                    wcnt <= wcnt_inc;
                end
            end

            // Drain updates touch only FULL/DRAINING banks, never the fill bank.
            if (drain_go) begin
                wr_addr <= base_q + burst_idx * BURST_BYTES;
            end

            if (drain_state == D_REQ) begin
                bank_state[drain_bank] <= B_DRAINING;
            end

            if (retire) begin
                bank_state[drain_bank] <= B_FREE;
                drain_bank             <= ~drain_bank;
                if (bank_last[drain_bank]) begin
                    layer_done <= 1'b1;
                    burst_idx  <= '0;
                end else begin
                    burst_idx <= burst_idx + ADDR_W'(1);
                end
            end
        end
    end

    // Buffer RAM: contents survive reset, only the bookkeeping is cleared.
    always_ff @(posedge clk) begin
        if (commit) begin
            data_mem[wr_idx] <= word_next;
            strb_mem[wr_idx] <= strb_next;
        end
    end

    assign rd_idx      = MEM_AW'(int'(drain_bank) * BURST_LEN + int'(rd_addr));
    assign rd_in_range = (int'(rd_addr) < int'(bank_cnt[drain_bank]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
            rd_strb <= '0;
        end else begin
            rd_data <= data_mem[rd_idx];
            rd_strb <= rd_in_range ? strb_mem[rd_idx] : 16'h0000;
        end
    end

endmodule
